// File: rtl/pkt_sink_checker.sv
// pkt_sink_checker: frames the 134-bit um output stream, applies backpressure and reports per-packet length, checksum and error plus running stats
module pkt_sink_checker #(
  parameter int BP_PERIOD = 0,
  parameter int MAX_WORDS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pktout_data_wr,
  input  logic [133:0] pktout_data,
  output logic         pktout_ready,
  input  logic         clr_stats,
  output logic         pkt_done,
  output logic [15:0]  pkt_len,
  output logic [31:0]  pkt_sum,
  output logic         pkt_err,
  output logic [31:0]  stat_pkt_cnt,
  output logic [31:0]  stat_byte_cnt,
  output logic [15:0]  stat_err_cnt
);
  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam bit BP_ON = BP_PERIOD >= 2;
  localparam logic [31:0] BP_LAST = 32'(BP_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  state_t           st_q, st_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [15:0]      len_q, len_d;
  logic [31:0]      sum_q, sum_d;
  logic             err_q, err_d;
  logic [31:0]      bp_cnt_q, bp_cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [15:0]      plen_q, plen_d;
  logic [31:0]      psum_q, psum_d;
  logic             perr_q, perr_d;
  logic [31:0]      spk_q, spk_d;
  logic [31:0]      sby_q, sby_d;
  logic [15:0]      ser_q, ser_d;

  logic             acc, is_head, is_tail, is_body, inv_err, close, orphan, c_err, err_inc;
  logic [3:0]       inv;
  logic [4:0]       tail_bytes;
  logic [127:0]     mdat;
  logic [31:0]      fold, c_sum;
  logic [15:0]      c_len;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign acc        = pktout_data_wr && ready_q;
  assign inv        = pktout_data[131:128];
  assign is_head    = pktout_data[133:132] == 2'b01;
  assign is_body    = pktout_data[133:132] == 2'b11;
  assign is_tail    = pktout_data[133:132] == 2'b10;
  assign inv_err    = !is_tail && inv != 4'd0;
  assign tail_bytes = is_tail ? 5'd16 - {1'b0, inv} : 5'd16;

  // invalid tail bytes sit at the low end of the word and are zeroed before folding
  always_comb begin
    mdat = pktout_data[127:0];
    for (int i = 0; i < 16; i++)
      mdat[127-8*i -: 8] = (is_tail && 5'(i) >= 5'd16 - {1'b0, inv}) ? 8'h00 : pktout_data[127-8*i -: 8];
    fold = mdat[127:96] ^ mdat[95:64] ^ mdat[63:32] ^ mdat[31:0];
  end

  always_comb begin
    st_d   = st_q;
    wcnt_d = wcnt_q;
    len_d  = len_q;
    sum_d  = sum_q;
    err_d  = err_q;
    close  = 1'b0;
    orphan = 1'b0;
    c_len  = len_q;
    c_sum  = sum_q;
    c_err  = err_q;
    if (acc) begin
      if (is_head) begin
        close  = st_q != IDLE;
        c_err  = 1'b1;
        st_d   = IN_PKT;
        wcnt_d = WCW'(1);
        len_d  = 16'd16;
        sum_d  = fold;
        err_d  = inv_err;
      end else if (st_q == IDLE) begin
        orphan = 1'b1;
      end else if (is_tail) begin
        close = 1'b1;
        st_d  = IDLE;
        c_len = st_q == DROP ? len_q : sat_add(len_q, tail_bytes);
        c_sum = st_q == DROP ? sum_q : sum_q ^ fold;
        c_err = err_q || st_q == DROP;
      end else if (st_q == IN_PKT) begin
        if (wcnt_q == WCW'(MAX_WORDS)) begin
          st_d  = DROP;
          err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
          len_d  = is_body ? sat_add(len_q, 5'd16) : len_q;
          sum_d  = is_body ? sum_q ^ fold : sum_q;
          err_d  = err_q || inv_err || !is_body;
        end
      end
    end
  end

  // ready is registered from the next count so it lines up with the counter phase
  always_comb begin
    bp_cnt_d = !BP_ON ? 32'd0 : (bp_cnt_q == BP_LAST ? 32'd0 : bp_cnt_q + 32'd1);
    ready_d  = !BP_ON || bp_cnt_d != BP_LAST;
    done_d   = close;
    plen_d   = close ? c_len : plen_q;
    psum_d   = close ? c_sum : psum_q;
    perr_d   = close ? c_err : perr_q;
    err_inc  = (pktout_data_wr && !ready_q) || orphan || (close && c_err);
    spk_d    = clr_stats ? 32'd0 : spk_q + {31'b0, close};
    sby_d    = clr_stats ? 32'd0 : sby_q + (close ? {16'b0, c_len} : 32'd0);
    ser_d    = clr_stats ? 16'd0 : ser_q + {15'b0, err_inc && ser_q != 16'hFFFF};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      wcnt_q   <= '0;
      len_q    <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
      bp_cnt_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      plen_q   <= '0;
      psum_q   <= '0;
      perr_q   <= 1'b0;
      spk_q    <= '0;
      sby_q    <= '0;
      ser_q    <= '0;
    end else begin
      st_q     <= st_d;
      wcnt_q   <= wcnt_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
      bp_cnt_q <= bp_cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      plen_q   <= plen_d;
      psum_q   <= psum_d;
      perr_q   <= perr_d;
      spk_q    <= spk_d;
      sby_q    <= sby_d;
      ser_q    <= ser_d;
    end
  end

  assign pktout_ready  = ready_q;
  assign pkt_done      = done_q;
  assign pkt_len       = plen_q;
  assign pkt_sum       = psum_q;
  assign pkt_err       = perr_q;
  assign stat_pkt_cnt  = spk_q;
  assign stat_byte_cnt = sby_q;
  assign stat_err_cnt  = ser_q;
endmodule

// File: tb/tb_pkt_sink_checker.sv
// tb_pkt_sink_checker: directed scoreboard bench for pkt_sink_checker (u0: no backpressure, 4-word max; u1: period-4 backpressure)
module tb_pkt_sink_checker;
  logic clk = 1'b0, rst = 1'b1;
  logic wr0 = 1'b0, clr0 = 1'b0, wr1 = 1'b0, clr1 = 1'b0;
  logic [133:0] d0 = '0, d1 = '0;
  logic rdy0, done0, err0, rdy1, done1, err1;
  logic [15:0] len0, ser0, len1, ser1;
  logic [31:0] sum0, spk0, sby0, sum1, spk1, sby1;

  localparam logic [1:0] H = 2'b01, B = 2'b11, T = 2'b10;

  typedef struct packed {logic [15:0] len; logic [31:0] sum; logic err;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [133:0] w [10];
  logic [31:0] s;

  always #5 clk = ~clk;

  pkt_sink_checker #(.BP_PERIOD(0), .MAX_WORDS(4)) u0 (
    .clk(clk), .rst(rst), .pktout_data_wr(wr0), .pktout_data(d0), .pktout_ready(rdy0),
    .clr_stats(clr0), .pkt_done(done0), .pkt_len(len0), .pkt_sum(sum0), .pkt_err(err0),
    .stat_pkt_cnt(spk0), .stat_byte_cnt(sby0), .stat_err_cnt(ser0));

  pkt_sink_checker #(.BP_PERIOD(4), .MAX_WORDS(128)) u1 (
    .clk(clk), .rst(rst), .pktout_data_wr(wr1), .pktout_data(d1), .pktout_ready(rdy1),
    .clr_stats(clr1), .pkt_done(done1), .pkt_len(len1), .pkt_sum(sum1), .pkt_err(err1),
    .stat_pkt_cnt(spk1), .stat_byte_cnt(sby1), .stat_err_cnt(ser1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fold(input logic [133:0] x);
    logic [127:0] d;
    d = x[127:0];
    if (x[133:132] == 2'b10) d = d & ({128{1'b1}} << (8 * x[131:128]));
    return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
  endfunction

  function automatic logic [133:0] wd(input logic [1:0] t, input logic [3:0] inv, input logic [127:0] d);
    return {t, inv, d};
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic w0(input logic [133:0] d);
    @(negedge clk);
    wr0 = 1'b1;
    d0 = d;
  endtask

  task automatic idle0(input int n);
    repeat (n) begin
      @(negedge clk);
      wr0 = 1'b0;
      clr0 = 1'b0;
    end
  endtask

  task automatic w1(input logic [133:0] d);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy1) begin
        wr1 = 1'b1;
        d1 = d;
        return;
      end
      wr1 = 1'b0;
    end
    chk("w1_ready_timeout", 32'(rdy1), 32'd1);
  endtask

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) chk("u0_unexpected_done", 32'(done0), 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("u0_pkt_len", 32'(len0), 32'(e0.len));
        chk("u0_pkt_sum", sum0, e0.sum);
        chk("u0_pkt_err", 32'(err0), 32'(e0.err));
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 32'(done1), 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("u1_pkt_len", 32'(len1), 32'(e1.len));
        chk("u1_pkt_sum", sum1, e1.sum);
        chk("u1_pkt_err", 32'(err1), 32'(e1.err));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_ready_bp", 32'(rdy1), 32'd0);
    chk("rst_outs", 32'({done0, err0, len0}), 32'd0);
    chk("rst_sum", sum0, 32'd0);
    chk("rst_stats", spk0 | sby0 | 32'(ser0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_rise", 32'(rdy0), 32'd1);

    // basic packet: head, 2 body, tail with 4 invalid bytes
    w[0] = wd(H, 4'd0, rnd()); w[1] = wd(B, 4'd0, rnd()); w[2] = wd(B, 4'd0, rnd()); w[3] = wd(T, 4'd4, rnd());
    q0.push_back('{16'd60, fold(w[0]) ^ fold(w[1]) ^ fold(w[2]) ^ fold(w[3]), 1'b0});
    for (int i = 0; i < 4; i++) w0(w[i]);
    idle0(1);
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_pkt_cnt", spk0, 32'd1);
    chk("t1_byte_cnt", sby0, 32'd60);
    idle0(1);
    chk("t1_pulse", 32'(done0), 32'd0);
    chk("t1_len_hold", 32'(len0), 32'd60);

    // all-ones checksum case
    q0.push_back('{16'd17, 32'hFF000000, 1'b0});
    w0(wd(H, 4'd0, '1));
    w0(wd(T, 4'd15, '1));
    idle0(1);
    chk("t2_done", 32'(done0), 32'd1);
    chk("t2_byte_cnt", sby0, 32'd77);
    idle0(3);
    chk("t2_sum_hold", sum0, 32'hFF000000);

    // missing tail: head, body, head, tail
    w[0] = wd(H, 4'd0, rnd()); w[1] = wd(B, 4'd0, rnd()); w[2] = wd(H, 4'd0, rnd()); w[3] = wd(T, 4'd0, rnd());
    q0.push_back('{16'd32, fold(w[0]) ^ fold(w[1]), 1'b1});
    q0.push_back('{16'd32, fold(w[2]) ^ fold(w[3]), 1'b0});
    w0(w[0]); w0(w[1]); w0(w[2]); w0(w[3]);
    chk("t3_hoh_done", 32'(done0), 32'd1);
    idle0(1);
    chk("t3_done2", 32'(done0), 32'd1);
    chk("t3_err_cnt", 32'(ser0), 32'd1);
    chk("t3_pkt_cnt", spk0, 32'd4);

    @(negedge clk);
    clr0 = 1'b1;
    idle0(1);
    chk("clr_stats", spk0 | sby0 | 32'(ser0), 32'd0);

    // orphan then overlong packet (MAX_WORDS=4)
    w0(wd(B, 4'd0, rnd()));
    idle0(1);
    chk("t4_orphan_err", 32'(ser0), 32'd1);
    chk("t4_orphan_no_done", 32'(done0), 32'd0);
    w[0] = wd(H, 4'd0, rnd());
    for (int i = 1; i < 6; i++) w[i] = wd(B, 4'd0, rnd());
    w[6] = wd(T, 4'd0, rnd());
    q0.push_back('{16'd64, fold(w[0]) ^ fold(w[1]) ^ fold(w[2]) ^ fold(w[3]), 1'b1});
    for (int i = 0; i < 7; i++) w0(w[i]);
    idle0(1);
    chk("t4_done", 32'(done0), 32'd1);
    chk("t4_err_cnt", 32'(ser0), 32'd2);
    chk("t4_byte_cnt", sby0, 32'd64);

    // clear in the closing cycle wins over the increment
    w[0] = wd(H, 4'd0, rnd()); w[1] = wd(T, 4'd0, rnd());
    q0.push_back('{16'd32, fold(w[0]) ^ fold(w[1]), 1'b0});
    w0(w[0]);
    w0(w[1]);
    clr0 = 1'b1;
    idle0(1);
    chk("clr_done", 32'(done0), 32'd1);
    chk("clr_priority", spk0 | sby0 | 32'(ser0), 32'd0);

    // backpressure pattern on u1
    for (int i = 0; i < 8 && rdy1 !== 1'b0; i++) @(negedge clk);
    chk("bp_low_found", 32'(rdy1), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("bp_high", 32'(rdy1), 32'd1);
    end
    @(negedge clk);
    chk("bp_low_period", 32'(rdy1), 32'd0);
    wr1 = 1'b1;
    d1 = wd(H, 4'd0, rnd());
    @(negedge clk);
    wr1 = 1'b0;
    chk("bp_drop_err", 32'(ser1), 32'd1);
    chk("bp_drop_no_pkt", spk1, 32'd0);
    w[0] = wd(H, 4'd0, rnd());
    for (int i = 1; i < 9; i++) w[i] = wd(B, 4'd0, rnd());
    w[9] = wd(T, 4'd0, rnd());
    s = '0;
    for (int i = 0; i < 10; i++) s = s ^ fold(w[i]);
    q1.push_back('{16'd160, s, 1'b0});
    for (int i = 0; i < 10; i++) w1(w[i]);
    @(negedge clk);
    wr1 = 1'b0;
    chk("bp_done", 32'(done1), 32'd1);
    chk("bp_byte_cnt", sby1, 32'd160);
    chk("bp_err_cnt", 32'(ser1), 32'd1);

    // reset mid-packet
    w[0] = wd(H, 4'd0, rnd()); w[1] = wd(T, 4'd0, rnd());
    q0.push_back('{16'd32, fold(w[0]) ^ fold(w[1]), 1'b0});
    w0(w[0]); w0(w[1]);
    idle0(1);
    chk("pre_rst_pkt_cnt", spk0, 32'd1);
    w0(wd(H, 4'd0, rnd()));
    w0(wd(B, 4'd0, rnd()));
    @(negedge clk);
    wr0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_stats", spk0 | sby0 | 32'(ser0), 32'd0);
    chk("rst_async_ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle0(2);
    chk("rst_no_done", 32'(done0), 32'd0);
    w0(wd(T, 4'd0, rnd()));
    idle0(1);
    chk("rst_tail_orphan", 32'(ser0), 32'd1);
    chk("rst_tail_no_done", 32'(done0), 32'd0);
    idle0(2);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
